// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the instruction-fetch path and the
// load/store path. One transaction is in flight at a time: a request is
// granted in IDLE, driven on the memory port in ISSUE until accepted, and its
// response is routed back to the owning requester from WAIT.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   if_req/if_addr            fetch request and byte address
//   if_ready/if_rvalid        fetch accept pulse / read-data-valid pulse
//   if_rdata                  last fetched word
//   d_req/d_we/d_addr/
//   d_wdata/d_be              load/store request and its fields
//   d_ready/d_rvalid          data accept pulse / response pulse
//   d_rdata                   last data response word
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be          registered memory request fields
//   mem_ready/mem_rvalid/
//   mem_rdata                 memory accept, response strobe, read data
//   busy                      a transaction is in progress
//   owner                     0 = fetch, 1 = data (current or last owner)
//
// state  | meaning
// IDLE   | arbitrate; a grant loads mem_* and pulses the winner's ready
// ISSUE  | mem_req high, fields held until mem_ready
// WAIT   | request accepted, waiting for mem_rvalid of the owner

module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_be,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [3:0] STREAK_LIMIT = 4'(STREAK_MAX);

  logic [1:0] state;
  logic [3:0] streak;
  logic       grant_d;
  logic       grant_f;

  // Data wins unless fetch has been passed over STREAK_MAX times in a row.
  assign grant_d = d_req && (!if_req || (streak != STREAK_LIMIT));
  assign grant_f = if_req && !grant_d;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      streak    <= 4'd0;
      owner     <= 1'b0;
      if_ready  <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_ready   <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'd0;
    end else begin
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            d_ready   <= 1'b1;
            owner     <= 1'b1;
            state     <= ST_ISSUE;
            // Only a grant that actually bypasses a waiting fetch counts.
            if (if_req && (streak != STREAK_LIMIT)) begin
              streak <= streak + 4'd1;
            end
          end else if (grant_f) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= 4'b1111;
            if_ready  <= 1'b1;
            owner     <= 1'b0;
            streak    <= 4'd0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (owner) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        owner;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.DATA_WIDTH(32), .STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // ctl = {if_ready, if_rvalid, d_ready, d_rvalid, mem_req, busy, owner}
  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        mr;
    logic        mv;
    logic [31:0] mrd;
    logic [6:0]  ctl;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  ebe;
    logic        ewe;
    logic [31:0] eird;
    logic [31:0] edrd;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [3:0] dbe,
                         input logic mr, input logic mv, input logic [31:0] mrd,
                         input logic [6:0] ctl, input logic [31:0] eaddr,
                         input logic [31:0] ewdata, input logic [3:0] ebe,
                         input logic ewe, input logic [31:0] eird,
                         input logic [31:0] edrd);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.dwd = dwd; v.dbe = dbe; v.mr = mr; v.mv = mv; v.mrd = mrd;
    v.ctl = ctl; v.eaddr = eaddr; v.ewdata = ewdata; v.ebe = ebe;
    v.ewe = ewe; v.eird = eird; v.edrd = edrd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = 4'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [6:0] ctl_now();
    return {if_ready, if_rvalid, d_ready, d_rvalid, mem_req, busy, owner};
  endfunction

  initial begin
    bit   exp_d[10];
    int   n_grant;
    logic [31:0] save_ird;
    logic [31:0] save_drd;

    rst = 1'b1;
    clear_inputs();

    // reset; single load; store/fetch collision
    //       rst ir ia   dr dw da       dwd          dbe  mr mv mrd
    //       ctl         eaddr    ewdata       ebe  ewe eird  edrd
    add_vec(1, 0, 0,    0, 0, 0,     0,           0,   0, 0, 0,
            7'b0000000, 0,       0,           0,   0,  0,    0);
    add_vec(0, 0, 0,    1, 0, 'h100, 0,           'hF, 1, 0, 0,
            7'b0010111, 'h100,   0,           'hF, 0,  0,    0);
    add_vec(0, 0, 0,    1, 0, 'h100, 0,           'hF, 1, 0, 0,
            7'b0000011, 'h100,   0,           'hF, 0,  0,    0);
    add_vec(0, 0, 0,    0, 0, 0,     0,           0,   0, 1, 'hDEADBEEF,
            7'b0001001, 'h100,   0,           'hF, 0,  0,    'hDEADBEEF);
    add_vec(0, 0, 0,    0, 0, 0,     0,           0,   0, 0, 0,
            7'b0000001, 'h100,   0,           'hF, 0,  0,    'hDEADBEEF);
    add_vec(0, 1, 0,    1, 1, 'h200, 'h12345678,  'h3, 1, 0, 0,
            7'b0010111, 'h200,   'h12345678,  'h3, 1,  0,    'hDEADBEEF);
    add_vec(0, 1, 0,    1, 1, 'h200, 'h12345678,  'h3, 1, 0, 0,
            7'b0000011, 'h200,   'h12345678,  'h3, 1,  0,    'hDEADBEEF);
    add_vec(0, 1, 0,    0, 0, 0,     0,           0,   0, 1, 'hAAAA5555,
            7'b0001001, 'h200,   'h12345678,  'h3, 1,  0,    'hAAAA5555);
    add_vec(0, 1, 0,    0, 0, 0,     0,           0,   1, 0, 0,
            7'b1000110, 0,       0,           'hF, 0,  0,    'hAAAA5555);
    add_vec(0, 1, 0,    0, 0, 0,     0,           0,   1, 0, 0,
            7'b0000010, 0,       0,           'hF, 0,  0,    'hAAAA5555);
    add_vec(0, 0, 0,    0, 0, 0,     0,           0,   0, 1, 'h00000013,
            7'b0100000, 0,       0,           'hF, 0,  'h13, 'hAAAA5555);
    add_vec(0, 0, 0,    0, 0, 0,     0,           0,   0, 0, 0,
            7'b0000000, 0,       0,           'hF, 0,  'h13, 'hAAAA5555);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; if_req = vecs[i].ir; if_addr = vecs[i].ia;
      d_req = vecs[i].dr; d_we = vecs[i].dw; d_addr = vecs[i].da;
      d_wdata = vecs[i].dwd; d_be = vecs[i].dbe;
      mem_ready = vecs[i].mr; mem_rvalid = vecs[i].mv; mem_rdata = vecs[i].mrd;
      step();
      chk($sformatf("v%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].eaddr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].ewdata);
      chk($sformatf("v%0d mem_be", i), 32'(mem_be), 32'(vecs[i].ebe));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].ewe));
      chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].eird);
      chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].edrd);
    end

    // starvation guard: both requesters held high
    exp_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    do_reset();
    if_req = 1'b1; if_addr = 'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 'h80; d_be = 4'hF;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 'h1;
    n_grant = 0;
    for (int c = 0; c < 100 && n_grant < 10; c++) begin
      step();
      if (if_ready || d_ready) begin
        chk($sformatf("starve grant%0d is_data", n_grant), 32'(d_ready), 32'(exp_d[n_grant]));
        chk($sformatf("starve grant%0d single", n_grant), 32'(if_ready && d_ready), 0);
        chk($sformatf("starve grant%0d owner", n_grant), 32'(owner), 32'(exp_d[n_grant]));
        n_grant++;
      end
    end
    chk("starve grant count", n_grant, 10);

    // backpressure: store held in ISSUE for 5 cycles, stray rvalid in the middle
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 'h300; d_wdata = 'h0BADF00D; d_be = 4'b1100;
    step();
    chk("bp ready", 32'(d_ready), 1);
    chk("bp mem_req first", 32'(mem_req), 1);
    for (int i = 0; i < 5; i++) begin
      if (i >= 1) begin
        d_req = 1'b0; d_addr = 'hFFF; d_wdata = 'h0; d_we = 1'b0; d_be = 4'hF;
      end
      mem_ready = 1'b0;
      mem_rvalid = (i == 2);
      mem_rdata = 'hEEEEEEEE;
      step();
      chk($sformatf("bp%0d mem_req", i), 32'(mem_req), 1);
      chk($sformatf("bp%0d mem_addr", i), mem_addr, 'h300);
      chk($sformatf("bp%0d mem_wdata", i), mem_wdata, 'h0BADF00D);
      chk($sformatf("bp%0d mem_we_be", i), 32'({mem_we, mem_be}), 32'(5'b11100));
      chk($sformatf("bp%0d busy", i), 32'(busy), 1);
      chk($sformatf("bp%0d pulses", i), 32'({d_ready, d_rvalid, if_rvalid}), 0);
    end
    mem_rvalid = 1'b0;
    mem_ready = 1'b1;
    step();
    chk("bp accept mem_req", 32'(mem_req), 0);
    chk("bp accept busy", 32'(busy), 1);
    step();
    chk("bp single accept", 32'({mem_req, d_ready}), 0);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 'h77;
    step();
    chk("bp rvalid", 32'(d_rvalid), 1);
    chk("bp rdata", d_rdata, 'h77);
    mem_rvalid = 1'b0;
    step();
    chk("bp done", 32'({d_rvalid, busy}), 0);

    // reset while in WAIT, late response must be discarded
    d_req = 1'b1; d_we = 1'b0; d_addr = 'h400; d_wdata = '0; d_be = 4'hF;
    mem_ready = 1'b1;
    step();
    step();
    chk("rw in wait", 32'({busy, mem_req}), 32'(2'b10));
    d_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw rst ctl", 32'(ctl_now()), 0);
    chk("rw rst mem", 32'({mem_we, mem_be}), 0);
    chk("rw rst addr", mem_addr, 0);
    chk("rw rst wdata", mem_wdata, 0);
    chk("rw rst rdata", if_rdata | d_rdata, 0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 'hBAD0BAD0;
    step();
    chk("rw stray pulses", 32'({if_rvalid, d_rvalid, busy}), 0);
    mem_rvalid = 1'b0;
    step();
    chk("rw stray rdata", d_rdata, 0);
    chk("rw stray pulses2", 32'({if_rvalid, d_rvalid}), 0);
    d_req = 1'b1; d_addr = 'h104; mem_ready = 1'b1;
    step();
    chk("rw next ready", 32'(d_ready), 1);
    chk("rw next addr", mem_addr, 'h104);
    step();
    d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 'h11112222;
    step();
    chk("rw next rvalid", 32'(d_rvalid), 1);
    chk("rw next rdata", d_rdata, 'h11112222);
    mem_rvalid = 1'b0;
    step();

    // stray response while idle
    save_ird = if_rdata;
    save_drd = d_rdata;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("stray%0d pulses", i), 32'({if_rvalid, d_rvalid, busy}), 0);
      chk($sformatf("stray%0d if_rdata", i), if_rdata, save_ird);
      chk($sformatf("stray%0d d_rdata", i), d_rdata, save_drd);
    end
    mem_rvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
